// File: rtl/delay_pipe_sched.sv
// delay_pipe_sched: round-robin scheduler sharing one fixed-latency valid-delay
// unit among N_REQ requesters, with per-requester completion routing,
// in-flight credit limiting and a sticky return-mismatch flag.
//
// Ports:
//   clk        clock, all logic on rising edge
//   rst        synchronous active-high reset
//   en         1 = new grants allowed, 0 = drain only
//   req        per-requester request level
//   gnt        one-hot grant, combinational, same cycle as accepted req
//   dly_vld_i  registered issue strobe to the delay unit
//   dly_vld_o  return strobe from the delay unit
//   done       one-hot registered completion pulse
//   inflight   issued-but-not-done count
//   idle       inflight==0 and dly_vld_i==0
//   err        sticky flag: tracking tail disagreed with dly_vld_o
module delay_pipe_sched #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned DELAY        = 3,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic [N_REQ-1:0]                  req,
  output logic [N_REQ-1:0]                  gnt,
  output logic                              dly_vld_i,
  input  logic                              dly_vld_o,
  output logic [N_REQ-1:0]                  done,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              idle,
  output logic                              err
);

  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W-1:0]  idx;
  logic             gnt_any;
  logic [ID_W-1:0]  issue_id;
  logic             pipe_vld [DELAY];
  logic [ID_W-1:0]  pipe_id  [DELAY];
  logic             tail_vld;
  logic [ID_W-1:0]  tail_id;
  logic [N_REQ-1:0] done_nxt;
  logic [CNT_W-1:0] inflight_nxt;

  // Round-robin pick: first set request at or after ptr, wrapping around.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = '0;
    if (!rst && en && (inflight < CNT_W'(MAX_INFLIGHT)) && (|req)) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        idx = ID_W'((32'(ptr) + i) % N_REQ);
        if (!gnt_any && req[idx]) begin
          gnt_any  = 1'b1;
          gnt[idx] = 1'b1;
          gnt_id   = idx;
        end
      end
    end
  end

  assign tail_vld = pipe_vld[DELAY-1];
  assign tail_id  = pipe_id[DELAY-1];

  // Completion decode comes from the tracking tail, not from dly_vld_o,
  // so the credit count can never drift even if the delay unit misbehaves.
  always_comb begin
    done_nxt = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      done_nxt[i] = tail_vld && (tail_id == ID_W'(i));
    end
  end

  // Credit counter: a grant and a done in the same cycle cancel.
  always_comb begin
    inflight_nxt = inflight;
    if (gnt_any && !(|done)) begin
      inflight_nxt = inflight + 1'b1;
    end else if (!gnt_any && (|done)) begin
      inflight_nxt = inflight - 1'b1;
    end
  end

  // Pointer, issue register, tracking pipe, completion and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      dly_vld_i <= 1'b0;
      issue_id  <= '0;
      for (int unsigned s = 0; s < DELAY; s++) begin
        pipe_vld[s] <= 1'b0;
        pipe_id[s]  <= '0;
      end
      done     <= '0;
      inflight <= '0;
      idle     <= 1'b1;
      err      <= 1'b0;
    end else begin
      if (gnt_any) begin
        ptr <= (32'(gnt_id) == N_REQ - 1) ? '0 : ID_W'(gnt_id + 1'b1);
      end
      dly_vld_i   <= gnt_any;
      issue_id    <= gnt_id;
      // Stage 0 captures the issue cycle, so the tail lines up with dly_vld_o.
      pipe_vld[0] <= dly_vld_i;
      pipe_id[0]  <= issue_id;
      for (int unsigned s = 1; s < DELAY; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_id[s]  <= pipe_id[s-1];
      end
      done     <= done_nxt;
      inflight <= inflight_nxt;
      idle     <= (inflight_nxt == '0) && !gnt_any;
      err      <= err | (tail_vld != dly_vld_o);
    end
  end

endmodule

// File: tb/tb_delay_pipe_sched.sv
// Self-checking bench for delay_pipe_sched: directed stimulus pushes expected
// done pulses (cycle + vector) into a queue; a negedge monitor pops/compares.
module tb_delay_pipe_sched;

  localparam int unsigned N_REQ        = 4;
  localparam int unsigned DELAY        = 3;
  localparam int unsigned MAX_INFLIGHT = 4;
  localparam int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [3:0]       req;
  logic [3:0]       gnt;
  logic             dly_vld_i;
  logic             dly_vld_o;
  logic [3:0]       done;
  logic [CNT_W-1:0] inflight;
  logic             idle;
  logic             err;

  logic             force_ret;
  logic             suppress_ret;
  logic [DELAY-1:0] sr;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [3:0] vec;
  } exp_t;
  exp_t q[$];

  delay_pipe_sched #(
    .N_REQ(N_REQ), .DELAY(DELAY), .MAX_INFLIGHT(MAX_INFLIGHT)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .gnt(gnt),
    .dly_vld_i(dly_vld_i), .dly_vld_o(dly_vld_o), .done(done),
    .inflight(inflight), .idle(idle), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference delay unit with fault-injection controls.
  always @(posedge clk) begin
    if (rst) sr <= '0;
    else     sr <= {sr[DELAY-2:0], dly_vld_i};
  end
  assign dly_vld_o = (sr[DELAY-1] | force_ret) & ~suppress_ret;

  // Monitor: every done pulse must match the head of the queue in value and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].cyc < cyc) begin
      tests++; fails++;
      $display("FAIL done_missing: got nothing, required %b at cycle %0d (now %0d)",
               q[0].vec, q[0].cyc, cyc);
      void'(q.pop_front());
    end
    if (done !== 4'b0000) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL done_unexpected: got %b at cycle %0d, required none", done, cyc);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.vec !== done) begin
          fails++;
          $display("FAIL done_match: got %b at cycle %0d, required %b at cycle %0d",
                   done, cyc, e.vec, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    q.delete();
    nxt();
    rst = 1'b0;
  endtask

  task automatic push(input int c, input logic [3:0] v);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] g3 [0:7];
    int c0;
    g3 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0001, 4'b0010};

    // Reset held two cycles with all requests high.
    rst = 1'b1; en = 1'b1; req = 4'b1111; force_ret = 1'b0; suppress_ret = 1'b0;
    nxt();
    smp();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_dly_vld_i", 32'(dly_vld_i), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_inflight", 32'(inflight), 32'h0);
    chk("rst_idle", 32'(idle), 32'h1);
    chk("rst_err", 32'(err), 32'h0);
    nxt();
    rst = 1'b0; req = '0;
    nxt();

    // Single transaction from requester 2.
    c0 = cyc;
    req = 4'b0100;
    push(c0 + 5, 4'b0100);
    smp(); chk("single_gnt", 32'(gnt), 32'h4);
    nxt(); req = '0;
    smp(); chk("single_issue", 32'(dly_vld_i), 32'h1);
    chk("single_inflight_c1", 32'(inflight), 32'h1);
    nxt();
    for (int i = 2; i <= 6; i++) begin
      smp();
      if (i == 5) chk("single_inflight_c5", 32'(inflight), 32'h1);
      if (i == 6) begin
        chk("single_inflight_c6", 32'(inflight), 32'h0);
        chk("single_idle_c6", 32'(idle), 32'h1);
      end
      nxt();
    end

    // Credit cap with all four requesting.
    do_reset();
    c0 = cyc;
    req = 4'b1111;
    push(c0 + 5, 4'b0001); push(c0 + 6, 4'b0010); push(c0 + 7, 4'b0100);
    push(c0 + 8, 4'b1000); push(c0 + 11, 4'b0001); push(c0 + 12, 4'b0010);
    for (int i = 0; i <= 7; i++) begin
      smp();
      chk($sformatf("cap_gnt_c%0d", i), 32'(gnt), 32'(g3[i]));
      if (i == 4) chk("cap_inflight_c4", 32'(inflight), 32'h4);
      if (i == 6) chk("cap_inflight_c6", 32'(inflight), 32'h3);
      nxt();
    end
    req = '0;
    for (int i = 8; i <= 13; i++) begin
      smp();
      if (i == 9) chk("cap_inflight_c9", 32'(inflight), 32'h2);
      if (i == 13) begin
        chk("cap_inflight_c13", 32'(inflight), 32'h0);
        chk("cap_idle_c13", 32'(idle), 32'h1);
      end
      nxt();
    end

    // Round-robin fairness between requesters 1 and 3.
    do_reset();
    c0 = cyc;
    req = 4'b1010;
    push(c0 + 5, 4'b0010); push(c0 + 6, 4'b1000);
    push(c0 + 7, 4'b0010); push(c0 + 8, 4'b1000);
    for (int i = 0; i <= 3; i++) begin
      smp();
      chk($sformatf("rr_gnt_c%0d", i), 32'(gnt), (i % 2 == 0) ? 32'h2 : 32'h8);
      nxt();
    end
    req = '0;
    for (int i = 4; i <= 9; i++) begin
      smp();
      if (i == 9) chk("rr_idle_c9", 32'(idle), 32'h1);
      nxt();
    end

    // Spurious return with an empty tail.
    force_ret = 1'b1;
    smp(); chk("spur_err_before", 32'(err), 32'h0);
    nxt(); force_ret = 1'b0;
    smp(); chk("spur_err_set", 32'(err), 32'h1);
    nxt(); nxt();
    smp(); chk("spur_err_held", 32'(err), 32'h1);
    nxt();
    do_reset();
    smp(); chk("spur_err_cleared", 32'(err), 32'h0);
    nxt();

    // Withheld return: err rises, done still pulses.
    c0 = cyc;
    req = 4'b0001;
    push(c0 + 5, 4'b0001);
    smp(); nxt(); req = '0;
    nxt(); nxt(); nxt();
    suppress_ret = 1'b1;
    smp(); chk("miss_err_c4", 32'(err), 32'h0);
    nxt(); suppress_ret = 1'b0;
    smp(); chk("miss_err_c5", 32'(err), 32'h1);
    nxt(); nxt();
    do_reset();

    // en low blocks grants while in-flight entries drain.
    en = 1'b0; req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      smp(); chk("en0_gnt", 32'(gnt), 32'h0);
      nxt();
    end
    c0 = cyc;
    en = 1'b1; req = 4'b0011;
    push(c0 + 5, 4'b0001); push(c0 + 6, 4'b0010);
    smp(); chk("en_gnt_c0", 32'(gnt), 32'h1);
    nxt();
    smp(); chk("en_gnt_c1", 32'(gnt), 32'h2);
    nxt();
    en = 1'b0; req = 4'b1111;
    for (int i = 2; i <= 8; i++) begin
      smp();
      chk($sformatf("en_off_gnt_c%0d", i), 32'(gnt), 32'h0);
      if (i == 8) begin
        chk("en_off_inflight_c8", 32'(inflight), 32'h0);
        chk("en_off_idle_c8", 32'(idle), 32'h1);
      end
      nxt();
    end
    en = 1'b1; req = '0;
    do_reset();

    // Reset with three transactions in flight: dropped silently.
    req = 4'b0111;
    for (int i = 0; i <= 2; i++) begin
      smp(); chk($sformatf("mid_gnt_c%0d", i), 32'(gnt), 32'(4'b0001 << i));
      nxt();
    end
    req = '0; rst = 1'b1; q.delete();
    smp(); chk("mid_inflight_pre", 32'(inflight), 32'h3);
    nxt(); rst = 1'b0;
    smp();
    chk("mid_inflight_post", 32'(inflight), 32'h0);
    chk("mid_dly_vld_i_post", 32'(dly_vld_i), 32'h0);
    chk("mid_idle_post", 32'(idle), 32'h1);
    for (int i = 0; i < 6; i++) nxt();
    smp(); chk("mid_err", 32'(err), 32'h0);
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/delay_pipe_sched.md
Name: delay_pipe_sched

Overview:
Round-robin scheduler that shares one fixed-latency valid-delay unit among N_REQ requesters. It grants one requester per cycle and drives the delay unit's vld_i. It tags every issue with the requester ID and routes the returning vld_o back as a per-requester done pulse. It also limits in-flight issues to MAX_INFLIGHT and flags any mismatch between expected and actual returns.

Parameters:
N_REQ, 4, number of requesters (>=2)
DELAY, 3, cycles from dly_vld_i to dly_vld_o in the shared delay unit (>=1)
MAX_INFLIGHT, 4, max issued-but-not-done transactions (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
en  in  1  1 = new grants allowed; 0 = no grants, in-flight entries drain
req  in  N_REQ  per-requester request level
gnt  out  N_REQ  one-hot grant, combinational, same cycle as accepted req
dly_vld_i  out  1  registered issue strobe to delay unit
dly_vld_o  in  1  return strobe from delay unit
done  out  N_REQ  one-hot registered completion pulse
inflight  out  clog2(MAX_INFLIGHT+1)  current in-flight count
idle  out  1  inflight==0 and dly_vld_i==0
err  out  1  sticky return-mismatch flag

Behaviour:
- Reset (rst high at a clock edge): gnt=0, dly_vld_i=0, done=0, inflight=0, err=0, idle=1; RR pointer=0; tracking pipe cleared. Reset mid-operation drops all in-flight entries silently, with no done pulses. The delay unit is reset by the same top-level reset event, so no stale returns follow.
- Grant condition in cycle t: en=1 and inflight<MAX_INFLIGHT and |req.
  - gnt selects the first set req[k] searching from pointer upward with wrap-around (k = ptr, ptr+1, ..., N_REQ-1, 0, ...).
  - At most one gnt bit per cycle.
- On grant: pointer <= (k+1) mod N_REQ; otherwise pointer holds.
- Requester handshake: gnt[k] high while req[k] high = one accepted transaction. The requester drops req[k] the cycle after gnt unless it has another transaction. Holding req continuously = back-to-back requests, subject to RR fairness.
- Issue: grant in cycle t -> dly_vld_i=1 in cycle t+1, and requester ID k enters the tracking pipe.
- Tracking pipe: DELAY stages of {valid, id[clog2(N_REQ)-1:0]}. The entry for the issue in t+1 reaches the tail in cycle t+1+DELAY, the cycle dly_vld_o is expected.
- Completion:
  - Tail valid -> done[id]=1 in cycle t+2+DELAY. Round trip gnt->done = DELAY+2 cycles.
  - done is driven from the tracking tail regardless of dly_vld_o, so the count always stays consistent.
- inflight: +1 on each gnt cycle, -1 on each done cycle, both registered.
  - Simultaneous gnt and done -> unchanged.
  - Never exceeds MAX_INFLIGHT; a done in cycle t does not enable a grant until cycle t+1.
- err: set at the tail-compare cycle if tail.valid != dly_vld_o, in either direction. Held until rst; scheduling continues unaffected.
- en deasserted: gnt=0 immediately (combinational); pointer held; pipe drains normally; idle rises after the last done.
- Single requester: may be granted every cycle, up to the MAX_INFLIGHT cap.

Test Plan:
- Reset: hold rst 2 cycles with req=4'b1111 -> gnt=0, dly_vld_i=0, done=0, inflight=0, idle=1, err=0.
- Single transaction: req[2] high in cycle 0 only -> gnt=4'b0100 cycle 0, dly_vld_i=1 cycle 1, done=4'b0100 cycle 5, inflight=1 cycles 1–5 and 0 from cycle 6.
- Credit cap (DELAY=3, MAX_INFLIGHT=4): req=4'b1111 held -> grants to 0,1,2,3 in cycles 0–3; no grant cycles 4–5 (inflight=4); done[0] cycle 5; grant to req 0 cycle 6.
- RR fairness: req=4'b1010 held, MAX_INFLIGHT large -> gnt alternates 4'b0010, 4'b1000, 4'b0010, ... with no starvation.
- Mismatch: force dly_vld_o=1 in a cycle with an empty tail -> err=1 next cycle and held until rst. Withhold an expected dly_vld_o -> err=1, done still pulses.
- en and mid-run reset: en=0 with pending req -> no gnt, in-flight entries still produce done, idle=1 afterwards. Assert rst with 3 in flight -> next cycle inflight=0, no done pulses, err stays 0.
